// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with pc, IF/ID register, halt FSM and fetch counter
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_halted;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc4;
  logic        w_is_halt;
  logic        w_unused_bits;

  // pc+4 wraps naturally at 2^32; used both for sequential fetch and bubble pc4
  assign w_pc4     = r_pc + 32'd4;
  assign w_is_halt = (imem_rdata == HALT_WORD);

  // redirect targets are word aligned, so the low byte-offset bits carry no information
  assign w_unused_bits = ^redirect_pc[1:0];

  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign pc          = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

  // Fetch FSM: priority is reset, redirect, halted, stall, then normal fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_halted      <= 1'b0;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_pc4         <= 32'd0;
      r_valid       <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (redirect) begin
      // the instruction fetched this cycle is on the wrong path: squash it
      r_state  <= S_RUN;
      r_halted <= 1'b0;
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_instr  <= 32'd0;
      r_pc4    <= w_pc4;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_HALTED: begin
          // parked on the halt word; keep feeding bubbles, stall has no effect
          r_instr <= 32'd0;
          r_pc4   <= w_pc4;
          r_valid <= 1'b0;
        end
        default: begin
          if (!stall) begin
            if (w_is_halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
              r_instr  <= 32'd0;
              r_pc4    <= w_pc4;
              r_valid  <= 1'b0;
            end else begin
              r_pc          <= w_pc4;
              r_instr       <= imem_rdata;
              r_pc4         <= w_pc4;
              r_valid       <= 1'b1;
              r_fetch_count <= r_fetch_count + 32'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into pc on reset.
REQ-002 Parameter IMEM_AW, default 10, instruction-memory word-address width.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, sentinel instruction that halts fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard hold; freezes pc and IF/ID register.
REQ-007 redirect  input  1  taken branch/jump from a later stage.
REQ-008 redirect_pc  input  32  target byte address for redirect.
REQ-009 imem_addr  output  IMEM_AW  word address to instruction memory.
REQ-010 imem_rdata  input  32  instruction word; combinational, valid in the same cycle as imem_addr.
REQ-011 pc  output  32  current fetch byte address.
REQ-012 if_id_instr  output  32  registered instruction to decode.
REQ-013 if_id_pc4  output  32  registered pc+4 of that instruction.
REQ-014 if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble.
REQ-015 halted  output  1  1 while the FSM is in HALTED.
REQ-016 fetch_count  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-017 imem_addr SHALL equal pc[IMEM_AW+1:2] combinationally.
REQ-018 Per-edge priority SHALL be reset > redirect > HALTED > stall > normal fetch.
REQ-019 FSM SHALL have two states, RUN and HALTED.
REQ-020 RUN, normal fetch, imem_rdata != HALT_WORD: pc <= pc+4 (mod 2^32); if_id_instr <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_count += 1.
REQ-021 RUN, normal fetch, imem_rdata == HALT_WORD: go to HALTED; pc held; IF/ID loaded with a bubble; fetch_count unchanged.
REQ-022 A bubble SHALL be if_id_instr = 0, if_id_valid = 0, and if_id_pc4 = current pc+4.
REQ-023 Stall (no redirect) SHALL hold pc, IF/ID, fetch_count and FSM state unchanged.
REQ-024 Redirect: pc <= {redirect_pc[31:2],2'b00}; IF/ID loaded with a bubble; state <= RUN; applies even with stall high or in HALTED.
REQ-025 redirect_pc[1:0] SHALL be ignored.
REQ-026 HALTED without redirect: pc held; IF/ID loaded with a bubble each cycle; stall ignored.
REQ-027 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-028 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 Latency: an instruction at address A SHALL appear on if_id_instr one edge after pc == A with no stall and no redirect.

Reset
REQ-030 On reset: pc = RESET_PC, if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0, fetch_count = 0, state = RUN, halted = 0.
REQ-031 Reset SHALL override stall, redirect and HALTED in the same cycle.
REQ-032 A mid-operation reset SHALL discard any in-flight IF/ID content.
REQ-033 Reset SHALL NOT be applied asynchronously; outputs change only on a clock edge.

Verification
REQ-034 Reset, then memory words 0x20080005, 0x20090003, 0x01095020 at 0, 4, 8 with no stall -> edges 1-3: if_id_instr shows each word, if_id_pc4 = 4, 8, 12, fetch_count = 3, pc = 12.
REQ-035 stall high for 2 cycles with pc = 8 -> pc stays 8, IF/ID unchanged, fetch_count unchanged; fetch resumes at 8 after stall drops.
REQ-036 redirect = 1, redirect_pc = 0x43 together with stall = 1 at pc = 12 -> next pc = 0x40, if_id_valid = 0, if_id_instr = 0.
REQ-037 HALT_WORD at 0x10 -> halted = 1, pc stays 0x10, if_id_valid = 0 for 5 cycles; redirect to 0x0 -> halted = 0, pc = 0.
REQ-038 Run until pc = 0xFFFFFFFC with fetch_count preloaded to 0xFFFFFFFF via a forced fetch -> pc wraps to 0, fetch_count wraps to 0.
REQ-039 Assert reset mid-stream while redirect = 1 -> pc = RESET_PC, all IF/ID fields 0, halted = 0, fetch_count = 0.
